// File: rtl/lll_write_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the LLL write arbiter.
// master = arbiter side, slave = requesters/engine side.
interface lll_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [3*NREQ-1:0]  req_wcnt;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    req_done;
  logic [NREQ-1:0]    req_err;
  logic               lll_start;
  logic [2:0]         lll_wcnt;
  logic [DW-1:0]      lll_data;
  logic               lll_done;
  logic               lll_err;
  logic               busy;
  logic               timeout_flag;

  modport master (
    input  req_valid, req_wcnt, req_data, lll_done, lll_err,
    output req_grant, req_done, req_err, lll_start, lll_wcnt, lll_data,
           busy, timeout_flag
  );

  modport slave (
    output req_valid, req_wcnt, req_data, lll_done, lll_err,
    input  req_grant, req_done, req_err, lll_start, lll_wcnt, lll_data,
           busy, timeout_flag
  );
endinterface

// File: rtl/lll_write_arbiter.sv
// Round-robin arbiter sharing one LLL write engine between NREQ requesters.
// Optional WAIT watchdog enabled by defining LLL_ARB_TIMEOUT_EN.
module lll_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  lll_write_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_REJECT
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   winner, last_grant, pick;
  logic            found;
  logic [2:0]      pick_wcnt;
  logic            pick_ok;
  logic [2:0]      wcnt_q;
  logic [DW-1:0]   data_q;
  logic            err_q;
  logic            timeout_hit;
  logic [NREQ-1:0] winner_oh;

  // Round-robin search starting just after the last served requester.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req_valid[(int'(last_grant) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last_grant) + i) % NREQ);
      end
    end
    pick_wcnt = bus.req_wcnt[int'(pick)*3 +: 3];
    pick_ok   = pick_wcnt inside {[3'd1:3'd4]};
  end

`ifdef LLL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          tflag;

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      tflag    <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else                 wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit && !bus.lll_done) tflag <= 1'b1;
    end
  end

  assign bus.timeout_flag = tflag;
`else
  assign timeout_hit      = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (found) state_nx = pick_ok ? S_START : S_REJECT;
      S_START:  state_nx = S_WAIT;
      // lll_done is only looked at here, which ignores it in every other state.
      S_WAIT:   if (bus.lll_done || timeout_hit) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      S_REJECT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner     <= '0;
      last_grant <= IW'(NREQ - 1);
      wcnt_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            winner <= pick;
            wcnt_q <= pick_wcnt;
            data_q <= bus.req_data[int'(pick)*DW +: DW];
            err_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.lll_done)     err_q <= bus.lll_err;
          else if (timeout_hit) err_q <= 1'b1;
        end
        S_RESP, S_REJECT: last_grant <= winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  assign bus.req_grant = (state != S_IDLE) ? winner_oh : '0;
  assign bus.req_done  = (state == S_RESP || state == S_REJECT) ? winner_oh : '0;
  assign bus.req_err   = (state == S_REJECT || (state == S_RESP && err_q)) ? winner_oh : '0;
  assign bus.lll_start = (state == S_START);
  assign bus.lll_wcnt  = wcnt_q;
  assign bus.lll_data  = data_q;
  assign bus.busy      = (state != S_IDLE);
endmodule
